// File: rtl/video_sync_tracker_pkg.sv
// ---------------------------------------------------------------------------
// video_sync_tracker_pkg
// Shared definitions for the video sync tracker:
//   - track_state_t : acquisition FSM encoding (SEARCH=0, ACQUIRE=1, LOCKED=2)
//   - default per-field line limits for NTSC (262/263-line fields) and
//     PAL (312/313-line fields)
//   - in_window()   : inclusive range test used for field-length and
//                     active-window decisions
// ---------------------------------------------------------------------------
package video_sync_tracker_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } track_state_t;

  // NTSC fields carry 262 or 263 lines; the window leaves room for
  // non-standard sources such as VCRs.
  localparam int NTSC_LINES_MIN = 240;
  localparam int NTSC_LINES_MAX = 320;

  // PAL fields carry 312 or 313 lines.
  localparam int PAL_LINES_MIN  = 288;
  localparam int PAL_LINES_MAX  = 336;

  // Inclusive range test: lo <= value <= hi.
  function automatic logic in_window(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/video_sync_tracker_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Registered rising-edge pulse generator for a bundle of level inputs.
// Each 0->1 transition yields exactly one cycle of 'rise' in the cycle
// after the high level is first sampled.
//
// The first clock after reset only loads the level history, so an input
// that is already high when reset is released is not reported as an edge.
//
// Ports:
//   clk     in          clock
//   reset_n in          asynchronous active-low reset
//   level   in  WIDTH   input levels, already synchronous to clk
//   rise    out WIDTH   registered one-cycle rising-edge events
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_r;
  logic             primed_r;

  // Level history and registered edge events; history starts at 0 and
  // edge reporting is held off until the history holds a real sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r   <= {WIDTH{1'b0}};
      primed_r <= 1'b0;
      rise     <= {WIDTH{1'b0}};
    end else begin
      prev_r   <= level;
      primed_r <= 1'b1;
      rise     <= primed_r ? (level & ~prev_r) : {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/video_sync_tracker.sv
// ---------------------------------------------------------------------------
// video_sync_tracker
// Tracks the decoder's HSYNC/VSYNC/FID outputs, counts lines per field,
// validates field length and, once LOCK_FIELDS consecutive in-range fields
// have been seen, publishes line/field timing to downstream logic.
//
// Optional feature: define VIDEO_SYNC_TRACKER_TIMEOUT_EN to add an hsync
// watchdog that drops back to SEARCH after TIMEOUT_CLKS clocks without
// an hsync event. Without the macro TIMEOUT_CLKS only feeds the parameter
// sanity check.
//
// Ports:
//   clk          in         pixel/decoder clock
//   reset_n      in         asynchronous active-low reset
//   hsync_in     in         HSYNC level (synchronous)
//   vsync_in     in         VSYNC level (synchronous)
//   fid_in       in         field ID level
//   locked       out        high while locked
//   field_start  out        pulse at each accepted field start
//   line_start   out        pulse at each line start while locked
//   line_num     out LINE_W current line in field (0 when unlocked)
//   field_id     out        fid_in captured at the last vsync event
//   active       out        locked and inside the active line window
//   field_lines  out LINE_W line count of the last completed field
// ---------------------------------------------------------------------------
module video_sync_tracker
  import video_sync_tracker_pkg::*;
#(
  parameter int LINE_W       = 10,
  parameter int LOCK_FIELDS  = 3,
  parameter int LINES_MIN    = NTSC_LINES_MIN,
  parameter int LINES_MAX    = NTSC_LINES_MAX,
  parameter int ACTIVE_FIRST = 21,
  parameter int ACTIVE_LAST  = 260,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              fid_in,
  output logic              locked,
  output logic              field_start,
  output logic              line_start,
  output logic [LINE_W-1:0] line_num,
  output logic              field_id,
  output logic              active,
  output logic [LINE_W-1:0] field_lines
);

  // Reject parameter values the tracker cannot honour.
  if (LOCK_FIELDS < 1 || LOCK_FIELDS > 15 || TIMEOUT_CLKS < 1 ||
      LINES_MIN > LINES_MAX) begin : g_param_check
    $error("video_sync_tracker: illegal parameter combination");
  end

  localparam logic [3:0]        LOCK_N   = 4'(LOCK_FIELDS);
  localparam logic [LINE_W-1:0] LCNT_ONE = LINE_W'(1);
  localparam logic [LINE_W-1:0] LCNT_SAT = {LINE_W{1'b1}};

  logic [1:0]        rise_s;
  logic              hs_ev_s;
  logic              vs_ev_s;
  track_state_t      state_r;
  track_state_t      state_next_s;
  logic [3:0]        good_cnt_r;
  logic [3:0]        good_cnt_next_s;
  logic [LINE_W-1:0] line_cnt_r;
  logic [LINE_W-1:0] line_cnt_next_s;
  logic              in_range_s;
  logic              overflow_s;
  logic              timeout_s;
  logic              lock_next_s;

  sync_edge_detect #(
    .WIDTH (2)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   ({vsync_in, hsync_in}),
    .rise    (rise_s)
  );

  assign hs_ev_s = rise_s[0];
  assign vs_ev_s = rise_s[1];

  // Field length judged on the count reached when vsync arrives.
  assign in_range_s = in_window(32'(line_cnt_r), 32'(LINES_MIN), 32'(LINES_MAX));
  // The hsync that would push the count past LINES_MAX ends the lock;
  // a simultaneous vsync starts a new field instead.
  assign overflow_s = hs_ev_s && !vs_ev_s && (32'(line_cnt_r) >= 32'(LINES_MAX));

`ifdef VIDEO_SYNC_TRACKER_TIMEOUT_EN
  localparam int            WD_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CLKS);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  logic [WD_W-1:0] wd_cnt_r;

  assign timeout_s = (wd_cnt_r >= WD_LIMIT);

  // Hsync watchdog: clears on every hsync event, saturates at the limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (hs_ev_s) begin
      wd_cnt_r <= {WD_W{1'b0}};
    end else if (!timeout_s) begin
      wd_cnt_r <= wd_cnt_r + WD_ONE;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Line counter: vsync restarts the field (and wins over a coincident
  // hsync), hsync advances it with saturation.
  always_comb begin
    line_cnt_next_s = line_cnt_r;
    if (vs_ev_s) begin
      line_cnt_next_s = {LINE_W{1'b0}};
    end else if (hs_ev_s) begin
      line_cnt_next_s = (line_cnt_r == LCNT_SAT) ? line_cnt_r : line_cnt_r + LCNT_ONE;
    end else begin
      line_cnt_next_s = line_cnt_r;
    end
  end

  // Acquisition FSM next state; watchdog and overflow override field judging.
  always_comb begin
    state_next_s    = state_r;
    good_cnt_next_s = good_cnt_r;
    if (timeout_s) begin
      state_next_s    = SEARCH;
      good_cnt_next_s = 4'd0;
    end else if (vs_ev_s) begin
      case (state_r)
        SEARCH: begin
          // The field cut short by reset/search is never judged.
          state_next_s    = ACQUIRE;
          good_cnt_next_s = 4'd0;
        end
        ACQUIRE: begin
          if (in_range_s) begin
            good_cnt_next_s = good_cnt_r + 4'd1;
            if ((good_cnt_r + 4'd1) >= LOCK_N) begin
              state_next_s = LOCKED;
            end else begin
              state_next_s = ACQUIRE;
            end
          end else begin
            state_next_s    = ACQUIRE;
            good_cnt_next_s = 4'd0;
          end
        end
        LOCKED: begin
          if (in_range_s) begin
            state_next_s = LOCKED;
          end else begin
            state_next_s    = ACQUIRE;
            good_cnt_next_s = 4'd0;
          end
        end
        default: begin
          state_next_s    = SEARCH;
          good_cnt_next_s = 4'd0;
        end
      endcase
    end else if (overflow_s) begin
      state_next_s    = SEARCH;
      good_cnt_next_s = 4'd0;
    end else begin
      state_next_s    = state_r;
      good_cnt_next_s = good_cnt_r;
    end
  end

  assign lock_next_s = (state_next_s == LOCKED);

  // FSM and line counter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= SEARCH;
      good_cnt_r <= 4'd0;
      line_cnt_r <= {LINE_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      good_cnt_r <= good_cnt_next_s;
      line_cnt_r <= line_cnt_next_s;
    end
  end

  // Registered outputs, derived from next-state values so that locked,
  // field_start and the first line_num of a field change together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked      <= 1'b0;
      field_start <= 1'b0;
      line_start  <= 1'b0;
      line_num    <= {LINE_W{1'b0}};
      field_id    <= 1'b0;
      active      <= 1'b0;
      field_lines <= {LINE_W{1'b0}};
    end else begin
      locked      <= lock_next_s;
      field_start <= vs_ev_s && lock_next_s;
      line_start  <= (hs_ev_s || vs_ev_s) && lock_next_s;
      line_num    <= lock_next_s ? line_cnt_next_s : {LINE_W{1'b0}};
      active      <= lock_next_s &&
                     in_window(32'(line_cnt_next_s), 32'(ACTIVE_FIRST), 32'(ACTIVE_LAST));
      if (vs_ev_s) begin
        field_lines <= line_cnt_r;
        field_id    <= fid_in;
      end else begin
        field_lines <= field_lines;
        field_id    <= field_id;
      end
    end
  end

endmodule

// File: doc/video_sync_tracker.md
# video_sync_tracker

Tracks the TVP5147M1 sync outputs (HSYNC, VSYNC, FID) and sequences the video timing for the decoder interface. Rising edges of the sync inputs are converted to single-cycle events, lines are counted within each field, and the field structure is validated. Downstream logic receives line and field start pulses, line number, field ID and an active-window flag only after lock has been acquired.

## Interface
- LINE_W, 10: width of line counters.
- LOCK_FIELDS, 3: consecutive in-range fields required to reach lock (1..15).
- LINES_MIN, 240: minimum accepted lines per field.
- LINES_MAX, 320: maximum accepted lines per field.
- ACTIVE_FIRST, 21: first active line number (inclusive).
- ACTIVE_LAST, 260: last active line number (inclusive).
- TIMEOUT_CLKS, 4096: hsync watchdog limit in clocks; used only with the macro.
- clk  in  1  pixel/decoder clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- hsync_in  in  1  HSYNC level, already synchronous to clk.
- vsync_in  in  1  VSYNC level, already synchronous to clk.
- fid_in  in  1  field ID level.
- locked  out  1  high while in LOCKED.
- field_start  out  1  one-cycle pulse at each accepted field start.
- line_start  out  1  one-cycle pulse at each line start.
- line_num  out  LINE_W  current line number within the field.
- field_id  out  1  fid_in sampled at the last vsync event.
- active  out  1  high when locked and ACTIVE_FIRST <= line_num <= ACTIVE_LAST.
- field_lines  out  LINE_W  line count of the last completed field.

## Operation
- Edge stage: hs_ev and vs_ev are rising-edge events of hsync_in and vsync_in, registered, with one cycle per edge. Edge history resets to 0, so an input that is already high at reset release is not an edge.
- Line counter: vs_ev sets line_cnt to 0. Otherwise hs_ev increments line_cnt, saturating at 2^LINE_W-1. If vs_ev and hs_ev occur together, vs_ev wins and line_cnt becomes 0.
- On vs_ev: field_lines <= line_cnt and field_id <= fid_in. The field is in range if LINES_MIN <= line_cnt <= LINES_MAX.
- FSM states SEARCH, ACQUIRE, LOCKED. good_cnt is 4 bits.
  - SEARCH: on vs_ev, go to ACQUIRE with good_cnt=0. The first partial field is never judged.
  - ACQUIRE: on vs_ev with the field in range, good_cnt++. When good_cnt reaches LOCK_FIELDS, go to LOCKED. On vs_ev with the field out of range, good_cnt=0 and stay in ACQUIRE.
  - LOCKED: on vs_ev with the field out of range, go to ACQUIRE with good_cnt=0.
  - Any state: if line_cnt exceeds LINES_MAX without a vs_ev, go to SEARCH.
- field_start is asserted only on a vs_ev taken in LOCKED with the field in range. The vs_ev that completes acquisition also asserts field_start.
- line_start is asserted on hs_ev or vs_ev while LOCKED (and not on a losing transition).
- line_num mirrors line_cnt. It outputs 0 when not locked.

## Timing
- Reset values: locked=0, field_start=0, line_start=0, line_num=0, field_id=0, active=0, field_lines=0. FSM resets to SEARCH; good_cnt=0 and line_cnt=0.
- Latency: when input is first sampled high at edge k, the event is registered at k and the outputs update at edge k+1 (2-clock latency). All outputs are registered.
- locked rises in the same cycle as the field_start that completes acquisition. locked falls in the cycle after the failing vs_ev or the overflow, with no field_start.
- Back-to-back input edges (high one cycle, low one cycle) must each produce an event.
- Reset asserted mid-field forces all outputs to reset values immediately. After release, the tracker re-enters SEARCH.

## Configuration
- VIDEO_SYNC_TRACKER_TIMEOUT_EN defined: a watchdog counter clears on hs_ev and counts clocks otherwise. Reaching TIMEOUT_CLKS forces SEARCH from any state; locked drops the next cycle and good_cnt=0.
- VIDEO_SYNC_TRACKER_TIMEOUT_EN undefined: there is no watchdog and TIMEOUT_CLKS is unused. Lock is lost only on out-of-range fields or line overflow.

## Structure
- Shared package: FSM state encoding (SEARCH=0, ACQUIRE=1, LOCKED=2) and default line limits for NTSC/PAL field sizes.
- Sub-module sync_edge_detect (WIDTH=2): rising-edge pulse generator for hsync/vsync, with asynchronous active-low reset. It is instantiated once.

## Test plan
- Reset with hsync_in/vsync_in held high → all outputs 0 and no events after release until the inputs toggle.
- Partial field, then 3 fields of 262 lines (LOCK_FIELDS=3) → locked=1 and field_start on the 3rd judged vs_ev. field_lines=262; line_num counts 0..262; active high on lines 21..260.
- Locked, then a field of 200 lines → no field_start, locked=0 the next cycle, ACQUIRE. After 3 good fields, relock.
- hsync and vsync rising in the same cycle while locked → line_num=0, line_start=1, field_start=1.
- 321 hsyncs without vsync → locked drops at the 321st line; state is SEARCH.
- With the macro and TIMEOUT_CLKS=4096: stop hsync while locked → locked=0 at 4096 clocks + 1. Without the macro, locked stays 1.
